line_rasterizer: RTL

- Bresenham line-drawing stage directly upstream of the framebuffer writer.
- Accepts one line command: two endpoints plus a 32-bit color.
- Emits one packed pixel entry per cycle into the rasterizer-to-framebuffer-writer FIFO (RAST_FBW_FIFO_LEN bits wide).
- Stalls on FIFO full; never drops or duplicates a pixel.

---
 rtl/line_rasterizer_pkg.sv | 37 +++
 rtl/line_rasterizer_if.sv | 29 ++
 rtl/line_rasterizer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/line_rasterizer_pkg.sv
// Shared definitions for the line rasterizer and the framebuffer writer:
// widths, entry field positions, FSM states and the entry packing helper.
package line_rasterizer_pkg;

    localparam int unsigned RAST_FBW_FIFO_LEN = 96;
    localparam int unsigned LINE_LEN          = 9;
    localparam int unsigned COL_LEN           = 10;
    localparam int unsigned ERR_W             = 13;
    localparam int unsigned COLOR_W           = 32;

    // Entry fields use big-endian numbering: bit 0 is the MSB.
    localparam int unsigned Y_FIELD_END     = 15;
    localparam int unsigned X_FIELD_END     = 31;
    localparam int unsigned COLOR_FIELD_BEG = 32;
    localparam int unsigned COLOR_FIELD_END = 63;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef logic [0:RAST_FBW_FIFO_LEN-1] entry_t;

    function automatic entry_t pack_entry(input logic [COL_LEN-1:0]  x,
                                          input logic [LINE_LEN-1:0] y,
                                          input logic [COLOR_W-1:0]  color);
        entry_t e;
        e = '0;
        e[Y_FIELD_END-LINE_LEN+1 : Y_FIELD_END]   = y;
        e[X_FIELD_END-COL_LEN+1 : X_FIELD_END]    = x;
        e[COLOR_FIELD_BEG : COLOR_FIELD_END]      = color;
        return e;
    endfunction

endpackage

// File: rtl/line_rasterizer_if.sv
// Command input and pixel FIFO output of the line rasterizer.
// The rasterizer itself connects through the slave modport.
interface line_rasterizer_if;
    import line_rasterizer_pkg::*;

    logic                           cmd_valid;
    logic                           cmd_ready;
    logic [COL_LEN-1:0]             cmd_x0;
    logic [LINE_LEN-1:0]            cmd_y0;
    logic [COL_LEN-1:0]             cmd_x1;
    logic [LINE_LEN-1:0]            cmd_y1;
    logic [COLOR_W-1:0]             cmd_color;
    logic [0:RAST_FBW_FIFO_LEN-1]   fifo_data;
    logic                           fifo_wr_en;
    logic                           fifo_full;
    logic                           line_done;
    logic                           busy;

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, fifo_full,
        input  cmd_ready, fifo_data, fifo_wr_en, line_done, busy
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, fifo_full,
        output cmd_ready, fifo_data, fifo_wr_en, line_done, busy
    );

endinterface

// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: takes one line command and emits one packed
// pixel entry per non-full cycle into the framebuffer-writer FIFO.
module line_rasterizer
    import line_rasterizer_pkg::*;
(
    input  logic               PLB_clk,
    input  logic               reset,
    line_rasterizer_if.slave   bus
);

    localparam int unsigned E2_W = ERR_W + 1;
    localparam logic signed [ERR_W-1:0] ERR_ZERO = '0;

    state_e                   state_q, state_d;
    logic [COL_LEN-1:0]       x_q, x_d, x1_q, x1_d;
    logic [LINE_LEN-1:0]      y_q, y_d, y1_q, y1_d;
    logic [COLOR_W-1:0]       color_q, color_d;
    logic signed [ERR_W-1:0]  dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                     sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic                     cmd_ready_q, cmd_ready_d;
    logic                     busy_q, busy_d;
    logic                     line_done_q, line_done_d;

    logic [ERR_W-1:0]         abs_dx_c, abs_dy_c;
    logic signed [E2_W-1:0]   e2_c;
    logic                     step_x_c, step_y_c, at_end_c, wr_c;

    // Next-state, Bresenham step and write strobe.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        color_d     = color_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        err_d       = err_q;
        sx_neg_d    = sx_neg_q;
        sy_neg_d    = sy_neg_q;
        wr_c        = 1'b0;

        abs_dx_c = (x1_q >= x_q) ? ERR_W'(x1_q - x_q) : ERR_W'(x_q - x1_q);
        abs_dy_c = (y1_q >= y_q) ? ERR_W'(y1_q - y_q) : ERR_W'(y_q - y1_q);
        // One extra bit keeps 2*err exact over the full error range.
        e2_c     = E2_W'(err_q) + E2_W'(err_q);
        step_x_c = (e2_c >= E2_W'(dy_q));
        step_y_c = (e2_c <= E2_W'(dx_q));
        at_end_c = (x_q == x1_q) && (y_q == y1_q);

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    x_d     = bus.cmd_x0;
                    y_d     = bus.cmd_y0;
                    x1_d    = bus.cmd_x1;
                    y1_d    = bus.cmd_y1;
                    color_d = bus.cmd_color;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                dx_d     = signed'(abs_dx_c);
                dy_d     = signed'(ERR_W'(0) - abs_dy_c);
                err_d    = signed'(abs_dx_c - abs_dy_c);
                sx_neg_d = !(x_q < x1_q);
                sy_neg_d = !(y_q < y1_q);
                state_d  = DRAW;
            end
            DRAW: begin
                wr_c = !bus.fifo_full;
                if (wr_c) begin
                    if (at_end_c) begin
                        state_d = DONE;
                    end else begin
                        err_d = err_q + (step_x_c ? dy_q : ERR_ZERO)
                                      + (step_y_c ? dx_q : ERR_ZERO);
                        if (step_x_c) x_d = sx_neg_q ? x_q - COL_LEN'(1) : x_q + COL_LEN'(1);
                        if (step_y_c) y_d = sy_neg_q ? y_q - LINE_LEN'(1) : y_q + LINE_LEN'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        line_done_d = (state_d == DONE);
    end

    always_ff @(posedge PLB_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            color_q     <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            err_q       <= '0;
            sx_neg_q    <= 1'b0;
            sy_neg_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            line_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            color_q     <= color_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            err_q       <= err_d;
            sx_neg_q    <= sx_neg_d;
            sy_neg_q    <= sy_neg_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            line_done_q <= line_done_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.busy       = busy_q;
    assign bus.line_done  = line_done_q;
    assign bus.fifo_wr_en = wr_c;
    assign bus.fifo_data  = pack_entry(x_q, y_q, color_q);

endmodule
